// File: rtl/dpram_portb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dpram_portb_arbiter_if
// Brief    : Requester-side handshake bundle for the DPRAM port B arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dpram_portb_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/dpram_portb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dpram_portb_arbiter
// Brief    : Port B sharing between J1 data port and host loader, with
//            post-reset zero-fill and a starvation guard for the host.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_portb_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int CLEAR_WORDS = 16,
  parameter int MAX_WAIT    = 4
) (
  input  logic                clock,
  input  logic                rst_n,
  dpram_portb_arbiter_if.slave cpu,
  dpram_portb_arbiter_if.slave host,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                init_done
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] c_LAST_PTR =
      (ADDR_W+1)'((CLEAR_WORDS > 0) ? CLEAR_WORDS - 1 : 0);
  localparam logic [3:0]      c_MAX_WAIT = 4'(MAX_WAIT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_clr_ptr;
  logic [3:0]        r_wait_cnt;
  logic              r_init_done;
  logic              r_cpu_rvalid;
  logic              r_host_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_host_rdata;
  logic              w_cpu_gnt;
  logic              w_host_gnt;
  logic              w_host_force;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_host_force = 1'b0;
    w_host_gnt   = 1'b0;
    w_cpu_gnt    = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    case (r_state)
      ST_INIT: begin
        if (CLEAR_WORDS == 0) begin
          w_state_nxt = ST_RUN;
        end else begin
          ram_we   = 1'b1;
          ram_addr = r_clr_ptr[ADDR_W-1:0];
          if (r_clr_ptr == c_LAST_PTR) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_host_force = host.req && (r_wait_cnt >= c_MAX_WAIT);
        w_host_gnt   = host.req && (!cpu.req || w_host_force);
        w_cpu_gnt    = cpu.req && !w_host_gnt;
        if (w_host_gnt) begin
          ram_we    = host.we;
          ram_addr  = host.addr;
          ram_wdata = host.wdata;
        end else if (w_cpu_gnt) begin
          ram_we    = cpu.we;
          ram_addr  = cpu.addr;
          ram_wdata = cpu.wdata;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_ptr     <= '0;
      r_wait_cnt    <= '0;
      r_init_done   <= 1'b0;
      r_cpu_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_cpu_rdata   <= '0;
      r_host_rdata  <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        r_clr_ptr <= r_clr_ptr + 1'b1;
        if (w_state_nxt == ST_RUN) begin
          r_init_done <= 1'b1;
        end
      end else begin
        // Denied-cycle count only runs while the host is actually waiting.
        if (host.req && !w_host_gnt) begin
          if (r_wait_cnt != 4'hF) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end else begin
          r_wait_cnt <= 4'd0;
        end
      end
      r_cpu_rvalid  <= w_cpu_gnt;
      r_host_rvalid <= w_host_gnt;
      if (w_cpu_gnt) begin
        r_cpu_rdata <= ram_rdata;
      end
      if (w_host_gnt) begin
        r_host_rdata <= ram_rdata;
      end
    end
  end

  assign cpu.gnt     = w_cpu_gnt;
  assign cpu.rvalid  = r_cpu_rvalid;
  assign cpu.rdata   = r_cpu_rdata;
  assign host.gnt    = w_host_gnt;
  assign host.rvalid = r_host_rvalid;
  assign host.rdata  = r_host_rdata;
  assign init_done   = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_dpram_portb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_portb_arbiter
// Brief    : Randomized + directed bench with a behavioural port B model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_portb_arbiter;

  localparam int c_CW = 16;
  localparam int c_MW = 4;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst0_n = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  dpram_portb_arbiter_if #(.ADDR_W(16), .DATA_W(16)) cpu_if ();
  dpram_portb_arbiter_if #(.ADDR_W(16), .DATA_W(16)) host_if ();
  dpram_portb_arbiter_if #(.ADDR_W(16), .DATA_W(16)) c0_if ();
  dpram_portb_arbiter_if #(.ADDR_W(16), .DATA_W(16)) h0_if ();

  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_we, init_done;
  logic [15:0] ram0_addr, ram0_wdata, ram0_rdata;
  logic        ram0_we, init0_done;

  dpram_portb_arbiter #(.ADDR_W(16), .DATA_W(16), .CLEAR_WORDS(c_CW), .MAX_WAIT(c_MW)) u_dut (
    .clock(clock), .rst_n(rst_n), .cpu(cpu_if), .host(host_if),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .init_done(init_done));

  dpram_portb_arbiter #(.ADDR_W(16), .DATA_W(16), .CLEAR_WORDS(0), .MAX_WAIT(c_MW)) u_dut0 (
    .clock(clock), .rst_n(rst0_n), .cpu(c0_if), .host(h0_if),
    .ram_addr(ram0_addr), .ram_we(ram0_we), .ram_wdata(ram0_wdata),
    .ram_rdata(ram0_rdata), .init_done(init0_done));

  function automatic logic [15:0] seed_word(input int i);
    return 16'(i * 40503) ^ 16'h5A3C;
  endfunction

  // RAM port B models: combinational read, write-through while writing.
  logic [15:0] mem  [0:65535];
  logic [15:0] mem0 [0:65535];
  bit          mem_ready = 1'b0;
  assign ram_rdata  = ram_we  ? ram_wdata  : mem[ram_addr];
  assign ram0_rdata = ram0_we ? ram0_wdata : mem0[ram0_addr];

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) begin
        mem[i]  = seed_word(i);
        mem0[i] = seed_word(i);
      end
      mem_ready = 1'b1;
    end
    if (ram_we)  mem[ram_addr]   = ram_wdata;
    if (ram0_we) mem0[ram0_addr] = ram0_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: init sweep as a count of cycles, arbitration as a
  // denied-cycle streak, responses from a shadow copy of the RAM.
  logic [15:0] shadow [0:65535];
  bit          shadow_ready = 1'b0;
  bit          m_init, m_done, m_cv, m_hv;
  int          m_icnt, m_streak;
  logic [15:0] m_cd, m_hd;

  always @(negedge clock) begin
    logic        e_cg, e_hg, e_we;
    logic [15:0] e_addr, e_wd, rd;
    if (!shadow_ready) begin
      for (int i = 0; i < 65536; i++) shadow[i] = seed_word(i);
      shadow_ready = 1'b1;
    end
    if (!rst_n) begin
      m_init = 1'b1; m_icnt = 0; m_streak = 0; m_done = 1'b0;
      m_cv = 1'b0; m_hv = 1'b0; m_cd = 16'h0; m_hd = 16'h0;
    end
    e_cg = 1'b0; e_hg = 1'b0; e_we = 1'b0; e_addr = 16'h0; e_wd = 16'h0;
    if (m_init) begin
      if (c_CW > 0) begin
        e_we = 1'b1;
        e_addr = m_icnt[15:0];
      end
    end else begin
      e_hg = host_if.req && (!cpu_if.req || m_streak >= c_MW);
      e_cg = cpu_if.req && !e_hg;
      if (e_hg) begin
        e_we = host_if.we; e_addr = host_if.addr; e_wd = host_if.wdata;
      end else if (e_cg) begin
        e_we = cpu_if.we; e_addr = cpu_if.addr; e_wd = cpu_if.wdata;
      end
    end
    check("cpu_gnt", cpu_if.gnt, e_cg);
    check("host_gnt", host_if.gnt, e_hg);
    check("ram_we", ram_we, e_we);
    check("ram_addr", ram_addr, e_addr);
    check("ram_wdata", ram_wdata, e_wd);
    check("cpu_rvalid", cpu_if.rvalid, m_cv);
    check("host_rvalid", host_if.rvalid, m_hv);
    check("cpu_rdata", cpu_if.rdata, m_cd);
    check("host_rdata", host_if.rdata, m_hd);
    check("init_done", init_done, m_done);
    if (!rst_n) begin
      if (c_CW > 0) shadow[0] = 16'h0;
    end else if (m_init) begin
      if (c_CW > 0) shadow[m_icnt] = 16'h0;
      m_icnt++;
      if (m_icnt >= c_CW) begin
        m_init = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      rd = e_we ? e_wd : shadow[e_addr];
      if (e_we) shadow[e_addr] = e_wd;
      m_cv = e_cg;
      m_hv = e_hg;
      if (e_cg) m_cd = rd;
      if (e_hg) m_hd = rd;
      if (host_if.req && !e_hg) m_streak++;
      else m_streak = 0;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the grant edge.
  task automatic txn(input bit side, input bit we, input logic [15:0] a,
                     input logic [15:0] wd, output logic [15:0] rd, output int waits);
    bit got;
    if (side) begin
      host_if.req = 1'b1; host_if.we = we; host_if.addr = a; host_if.wdata = wd;
    end else begin
      cpu_if.req = 1'b1; cpu_if.we = we; cpu_if.addr = a; cpu_if.wdata = wd;
    end
    waits = 0;
    got = 1'b0;
    while (!got && waits < 50) begin
      @(negedge clock);
      waits++;
      got = side ? host_if.gnt : cpu_if.gnt;
    end
    check("txn_granted", got, 1'b1);
    @(posedge clock); #1;
    if (side) begin
      host_if.req = 1'b0;
      check("txn_host_rvalid", host_if.rvalid, 1'b1);
      check("txn_cpu_rvalid_idle", cpu_if.rvalid, 1'b0);
      rd = host_if.rdata;
    end else begin
      cpu_if.req = 1'b0;
      check("txn_cpu_rvalid", cpu_if.rvalid, 1'b1);
      check("txn_host_rvalid_idle", host_if.rvalid, 1'b0);
      rd = cpu_if.rdata;
    end
  endtask

  // Counts INIT cycles (init_done low) after release; also checks no early grant.
  task automatic wait_init(output int n);
    n = 0;
    forever begin
      @(negedge clock);
      if (init_done || n >= 100) break;
      if (cpu_if.gnt) check("gnt_during_init", cpu_if.gnt, 1'b0);
      n++;
    end
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [15:0] rd;
    int          w, n;
    bit          cg, hg;
    logic [9:0]  pat;
    cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = 0; cpu_if.wdata = 0;
    host_if.req = 0; host_if.we = 0; host_if.addr = 0; host_if.wdata = 0;
    c0_if.req = 0; c0_if.we = 0; c0_if.addr = 0; c0_if.wdata = 0;
    h0_if.req = 0; h0_if.we = 0; h0_if.addr = 0; h0_if.wdata = 0;

    // Zero-fill sweep with a cpu read already pending.
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h0003;
    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;
    wait_init(n);
    check("init_cycles", n, 16);
    check("first_gnt_with_init_done", cpu_if.gnt, 1'b1);
    @(posedge clock); #1;
    cpu_if.req = 1'b0;
    check("cleared_read_rvalid", cpu_if.rvalid, 1'b1);
    check("cleared_read_data", cpu_if.rdata, 16'h0000);

    // cpu write then back-to-back read.
    txn(1'b0, 1'b1, 16'h0100, 16'hBEEF, rd, w);
    check("cpu_write_echo", rd, 16'hBEEF);
    txn(1'b0, 1'b0, 16'h0100, 16'h0000, rd, w);
    check("cpu_read_back", rd, 16'hBEEF);

    // Both requesting continuously: host forced every MAX_WAIT+1 cycles.
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h0010;
    host_if.req = 1'b1; host_if.we = 1'b0; host_if.addr = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      pat[i] = host_if.gnt;
    end
    @(posedge clock); #1;
    cpu_if.req = 1'b0; host_if.req = 1'b0;
    check("grant_pattern", pat, 10'b10000_10000);

    // Host write/read at the top address, no contention.
    @(posedge clock); #1;
    txn(1'b1, 1'b1, 16'hFFFF, 16'h1234, rd, w);
    check("host_write_wait", w, 1);
    txn(1'b1, 1'b0, 16'hFFFF, 16'h0000, rd, w);
    check("host_read_wait", w, 1);
    check("host_read_data", rd, 16'h1234);

    // Reset while a response is due.
    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h0042;
    @(negedge clock);
    check("pre_reset_gnt", cpu_if.gnt, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("reset_rvalid", cpu_if.rvalid, 1'b0);
    check("reset_init_done", init_done, 1'b0);
    check("reset_ram_addr", ram_addr, 16'h0000);
    check("reset_ram_we", ram_we, 1'b1);
    cpu_if.req = 1'b0;
    @(negedge clock);
    @(posedge clock); #1 rst_n = 1'b1;
    wait_init(n);
    check("reinit_cycles", n, 16);
    @(posedge clock); #1;

    // Randomized traffic under the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clock);
      cg = cpu_if.gnt; hg = host_if.gnt;
      @(posedge clock); #1;
      if (!cpu_if.req || cg) begin
        cpu_if.req = ($urandom_range(0, 3) != 0);
        cpu_if.we = 1'($urandom_range(0, 1));
        cpu_if.addr = rand_addr();
        cpu_if.wdata = 16'($urandom);
      end
      if (!host_if.req || hg) begin
        host_if.req = ($urandom_range(0, 2) == 0);
        host_if.we = 1'($urandom_range(0, 1));
        host_if.addr = rand_addr();
        host_if.wdata = 16'($urandom);
      end
    end
    @(negedge clock);
    @(posedge clock); #1;
    cpu_if.req = 1'b0; host_if.req = 1'b0;

    // CLEAR_WORDS=0 instance: no sweep, memory survives reset.
    rst0_n = 1'b1;
    @(negedge clock);
    check("cw0_no_we_init", ram0_we, 1'b0);
    check("cw0_done_low", init0_done, 1'b0);
    @(posedge clock); #1;
    check("cw0_done_one_clock", init0_done, 1'b1);
    c0_if.req = 1'b1; c0_if.we = 1'b1; c0_if.addr = 16'h0005; c0_if.wdata = 16'hA5A5;
    @(negedge clock);
    check("cw0_write_gnt", c0_if.gnt, 1'b1);
    @(posedge clock); #1;
    c0_if.req = 1'b0;
    check("cw0_write_rvalid", c0_if.rvalid, 1'b1);
    rst0_n = 1'b0;
    @(negedge clock);
    check("cw0_reset_no_we", ram0_we, 1'b0);
    @(posedge clock); #1 rst0_n = 1'b1;
    @(negedge clock);
    check("cw0_init_no_we", ram0_we, 1'b0);
    @(posedge clock); #1;
    c0_if.req = 1'b1; c0_if.we = 1'b0; c0_if.addr = 16'h0005;
    @(negedge clock);
    check("cw0_read_gnt", c0_if.gnt, 1'b1);
    @(posedge clock); #1;
    c0_if.req = 1'b0;
    check("cw0_read_rvalid", c0_if.rvalid, 1'b1);
    check("cw0_survived", c0_if.rdata, 16'hA5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
